bf_tape_unit: RTL and testbench
===============================

Name: bf_tape_unit

Overview:
Data-tape execution stage of the Brainfuck processor, sitting directly upstream of the 256x8 data memory. It owns the data pointer and executes the tape ops `+ - > < . ,` by driving the memory's read address, write address, write data and load strobe, and by consuming the memory's asynchronous read data. Ops are accepted from the decode/control stage over a valid/ready handshake. Byte I/O is exchanged with the console over valid/ready handshakes. A cell-is-zero flag is exported to the loop/branch logic for `[` and `]`.

Parameters:
ADDR_W, 8, data pointer / memory address width (tape length = 2**ADDR_W)
DATA_W, 8, cell width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  control stage presents an op
op  in  3  op code (see bf_pkg)
op_ready  out  1  unit can accept an op this cycle
cell_zero  out  1  current cell (mem_rdata) == 0; meaningful only while op_ready=1
dp  out  ADDR_W  current data pointer (debug/trace)
mem_raddr  out  ADDR_W  memory read address, always equal to dp
mem_rdata  in  DATA_W  memory asynchronous read data
mem_waddr  out  ADDR_W  memory write address, always equal to dp
mem_wdata  out  DATA_W  memory write data
mem_load  out  1  memory write strobe
out_valid  out  1  output byte available
out_data  out  DATA_W  output byte
out_ready  in  1  console accepts output byte
in_valid  in  1  console offers input byte
in_data  in  DATA_W  input byte
in_ready  out  1  unit accepts input byte

Behaviour:
- Reset (async, rst_n=0): state=IDLE, dp=0, out_valid=0, out_data=0, in_ready=0, mem_load=0, op_ready=1 after release. Memory contents are not touched.
- Reset mid-operation: the pending op is abandoned and no further mem_load is issued. A write already committed stays in memory.
- FSM states: IDLE, WRITE, OUT_WAIT, IN_WAIT.
- op_ready = (state==IDLE). An op is accepted on a cycle with op_valid && op_ready.
- OP_RIGHT / OP_LEFT:
  - dp <= dp ± 1 at the accepting edge, modulo 2**ADDR_W (255+1 -> 0, 0-1 -> 255).
  - State stays IDLE, giving back-to-back throughput of 1 op/cycle.
- OP_INC / OP_DEC:
  - At accept, a latched result is captured: res <= mem_rdata ± 1 (mod 2**DATA_W; 255+1 -> 0, 0-1 -> 255). Go to WRITE.
  - WRITE: mem_load=1, mem_wdata=res, mem_waddr=dp for exactly one cycle, then IDLE.
  - Latency: 2 cycles accept-to-accept.
- OP_OUT:
  - At accept, out_data <= mem_rdata and out_valid <= 1. Go to OUT_WAIT.
  - OUT_WAIT holds out_data stable until out_ready=1. On that edge out_valid <= 0 and state goes to IDLE.
  - If out_ready is already high in the first OUT_WAIT cycle, completion takes 1 cycle.
- OP_IN:
  - At accept, in_ready <= 1. Go to IN_WAIT.
  - In IN_WAIT, on the cycle in_valid=1: mem_load=1 and mem_wdata=in_data combinationally in that same cycle. At that edge in_ready <= 0 and state goes to IDLE.
  - in_data is ignored outside IN_WAIT.
- OP_NOP and undefined codes: accepted, no effect, remain IDLE.
- mem_load is 0 in every state except WRITE, and except IN_WAIT when in_valid=1. When mem_load=0, mem_wdata is don't-care but driven to res.
- Read-after-write: an INC at cycle N followed by an OUT accepted at N+2 must see the incremented value, because memory writes on the edge ending WRITE.
- cell_zero = (mem_rdata == 0), purely combinational.
- op is sampled only when op_valid && op_ready. op_valid while busy is held off, not lost.

Decomposition:
- bf_pkg holds:
  - op_t enum (3 bits): OP_NOP=0, OP_INC=1, OP_DEC=2, OP_RIGHT=3, OP_LEFT=4, OP_OUT=5, OP_IN=6.
  - state_t enum: IDLE, WRITE, OUT_WAIT, IN_WAIT.
  - Default widths: ADDR_W=8, DATA_W=8.
- The same package is shared with the decode/control stage.
- No sub-module; the block is a single FSM plus pointer and result registers.

Test Plan:
1. Reset, then INC,INC,INC, OUT with out_ready=1 -> exactly 3 single-cycle mem_load pulses at addr 0 (wdata 1,2,3); out_data=3, out_valid one cycle.
2. LEFT from reset, then DEC -> dp=255, mem_load at addr 255 with wdata=255 (empty cell 0-1 wraps); cell_zero=0 afterwards.
3. RIGHT x256 back-to-back with op_valid held high -> op_ready stays 1 throughout, dp returns to 0 after the 256th accept.
4. Cell at 255, INC -> wdata=0 and cell_zero=1 in the next IDLE cycle.
5. IN with in_valid held low 5 cycles, then in_data=0x41 -> in_ready high for 6 cycles, one mem_load with wdata=0x41 in the in_valid cycle; OUT then yields 0x41.
6. OUT with out_ready low 4 cycles, rst_n pulsed low in cycle 2 -> out_valid drops immediately, dp=0, op_ready=1 after release, no mem_load seen.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared op codes, FSM states and default widths for the Brainfuck processor.
package bf_pkg;

  localparam int unsigned BF_ADDR_W = 8;
  localparam int unsigned BF_DATA_W = 8;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_INC   = 3'd1,
    OP_DEC   = 3'd2,
    OP_RIGHT = 3'd3,
    OP_LEFT  = 3'd4,
    OP_OUT   = 3'd5,
    OP_IN    = 3'd6
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    OUT_WAIT,
    IN_WAIT
  } state_t;

endpackage

// File: rtl/bf_tape_unit.sv
// Data-tape execution stage: owns the data pointer and executes + - > < . , against
// an asynchronous-read data memory, with valid/ready handshakes to control and console.
module bf_tape_unit
  import bf_pkg::*;
#(
  parameter int unsigned ADDR_W = BF_ADDR_W,
  parameter int unsigned DATA_W = BF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid_i,
  input  logic [2:0]        op_i,
  output logic              op_ready_o,
  output logic              cell_zero_o,
  output logic [ADDR_W-1:0] dp_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_load_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o
);

  state_t              state_q;
  logic [ADDR_W-1:0]   dp_q;
  logic [DATA_W-1:0]   res_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                in_ready_q;
  logic                in_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dp_q        <= '0;
      res_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (op_valid_i) begin
            case (op_t'(op_i))
              OP_INC: begin
                res_q   <= mem_rdata_i + DATA_W'(1);
                state_q <= WRITE;
              end
              OP_DEC: begin
                res_q   <= mem_rdata_i - DATA_W'(1);
                state_q <= WRITE;
              end
              OP_RIGHT: dp_q <= dp_q + ADDR_W'(1);
              OP_LEFT:  dp_q <= dp_q - ADDR_W'(1);
              OP_OUT: begin
                out_data_q  <= mem_rdata_i;
                out_valid_q <= 1'b1;
                state_q     <= OUT_WAIT;
              end
              OP_IN: begin
                in_ready_q <= 1'b1;
                state_q    <= IN_WAIT;
              end
              default: ;  // NOP and undefined codes are consumed silently
            endcase
          end
        end
        WRITE: state_q <= IDLE;
        OUT_WAIT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        IN_WAIT: begin
          if (in_valid_i) begin
            in_ready_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
      endcase
    end
  end

  // Input bytes go straight to memory in the cycle they arrive, bypassing res_q.
  assign in_write    = (state_q == IN_WAIT) && in_valid_i;
  assign mem_load_o  = (state_q == WRITE) || in_write;
  assign mem_wdata_o = in_write ? in_data_i : res_q;
  assign mem_raddr_o = dp_q;
  assign mem_waddr_o = dp_q;
  assign dp_o        = dp_q;
  assign op_ready_o  = (state_q == IDLE);
  assign cell_zero_o = (mem_rdata_i == '0);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign in_ready_o  = in_ready_q;

endmodule

// File: tb/tb_bf_tape_unit.sv
// Self-checking bench for bf_tape_unit: table of ops with expected pointer/zero flag,
// plus a scoreboard for memory writes and console output bytes.
module tb_bf_tape_unit;
  import bf_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic [2:0] op;
  logic       op_ready;
  logic       cell_zero;
  logic [7:0] dp;
  logic [7:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       mem_load;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  bf_tape_unit #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid_i (op_valid),
    .op_i       (op),
    .op_ready_o (op_ready),
    .cell_zero_o(cell_zero),
    .dp_o       (dp),
    .mem_raddr_o(mem_raddr),
    .mem_rdata_i(mem_rdata),
    .mem_waddr_o(mem_waddr),
    .mem_wdata_o(mem_wdata),
    .mem_load_o (mem_load),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_ready_i(out_ready),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready)
  );

  always #5 clk = ~clk;

  // Data memory: asynchronous read, write on rising edge; untouched by reset.
  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_raddr];
  always @(posedge clk) if (mem_load) mem[mem_waddr] <= mem_wdata;

  // Reference model state
  logic [7:0]  tape_m [256];
  logic [7:0]  dp_m;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_out[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Scoreboard: every write strobe and output handshake must match the next expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_load) begin
        if (exp_wr.size() == 0) timeout("unexpected mem_load");
        else check("mem write {addr,data}", {16'h0, mem_waddr, mem_wdata},
                   {16'h0, exp_wr.pop_front()});
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) timeout("unexpected output byte");
        else check("out_data", {24'h0, out_data}, {24'h0, exp_out.pop_front()});
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!op_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!op_ready) timeout("op_ready");
  endtask

  task automatic model_op(input logic [2:0] o, input logic [7:0] din);
    case (o)
      3'd1: begin
        exp_wr.push_back({dp_m, tape_m[dp_m] + 8'd1});
        tape_m[dp_m] = tape_m[dp_m] + 8'd1;
      end
      3'd2: begin
        exp_wr.push_back({dp_m, tape_m[dp_m] - 8'd1});
        tape_m[dp_m] = tape_m[dp_m] - 8'd1;
      end
      3'd3: dp_m = dp_m + 8'd1;
      3'd4: dp_m = dp_m - 8'd1;
      3'd5: exp_out.push_back(tape_m[dp_m]);
      3'd6: begin
        exp_wr.push_back({dp_m, din});
        tape_m[dp_m] = din;
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [7:0] din);
    int n;
    model_op(o, din);
    wait_idle();
    op_valid = 1'b1;
    op       = o;
    @(posedge clk); #1;
    op_valid = 1'b0;
    op       = 3'd0;
    if (o == 3'd6) begin
      in_valid = 1'b1;
      in_data  = din;
      n = 0;
      while (in_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (in_ready) timeout("in handshake");
      in_valid = 1'b0;
    end
    wait_idle();
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] din;
    logic [7:0] exp_dp;
    logic       exp_zero;
  } vec_t;

  vec_t vecs [19];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi;
    int bad;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'h00;
      tape_m[i] = 8'h00;
    end
    dp_m      = 8'h00;
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    op        = 3'd0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;

    //        op     din    dp     zero
    vecs[0]  = '{3'd1, 8'h00, 8'd0,   1'b0};  // INC x3 -> 1,2,3
    vecs[1]  = '{3'd1, 8'h00, 8'd0,   1'b0};
    vecs[2]  = '{3'd1, 8'h00, 8'd0,   1'b0};
    vecs[3]  = '{3'd5, 8'h00, 8'd0,   1'b0};  // OUT 3
    vecs[4]  = '{3'd4, 8'h00, 8'd255, 1'b1};  // LEFT wraps to 255
    vecs[5]  = '{3'd2, 8'h00, 8'd255, 1'b0};  // DEC 0 -> 255
    vecs[6]  = '{3'd3, 8'h00, 8'd0,   1'b0};  // RIGHT wraps to 0
    vecs[7]  = '{3'd3, 8'h00, 8'd1,   1'b1};
    vecs[8]  = '{3'd0, 8'h00, 8'd1,   1'b1};  // NOP
    vecs[9]  = '{3'd7, 8'h00, 8'd1,   1'b1};  // undefined code
    vecs[10] = '{3'd6, 8'h7f, 8'd1,   1'b0};  // IN 0x7f
    vecs[11] = '{3'd5, 8'h00, 8'd1,   1'b0};  // OUT 0x7f
    vecs[12] = '{3'd4, 8'h00, 8'd0,   1'b0};
    vecs[13] = '{3'd2, 8'h00, 8'd0,   1'b0};  // DEC x3 -> 2,1,0
    vecs[14] = '{3'd2, 8'h00, 8'd0,   1'b0};
    vecs[15] = '{3'd2, 8'h00, 8'd0,   1'b1};
    vecs[16] = '{3'd4, 8'h00, 8'd255, 1'b0};  // cell 255 holds 255
    vecs[17] = '{3'd1, 8'h00, 8'd255, 1'b1};  // INC 255 -> 0
    vecs[18] = '{3'd5, 8'h00, 8'd255, 1'b1};  // OUT 0

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset dp", {24'h0, dp}, 32'h0);
    check("reset op_ready", {31'h0, op_ready}, 32'h1);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    check("reset out_data", {24'h0, out_data}, 32'h0);
    check("reset in_ready", {31'h0, in_ready}, 32'h0);
    check("reset mem_load", {31'h0, mem_load}, 32'h0);

    for (int i = 0; i < 19; i++) begin
      run_op(vecs[i].op, vecs[i].din);
      check($sformatf("vec%0d dp", i), {24'h0, dp}, {24'h0, vecs[i].exp_dp});
      check($sformatf("vec%0d cell_zero", i), {31'h0, cell_zero}, {31'h0, vecs[i].exp_zero});
    end

    // IN with console stalling for 5 cycles
    model_op(3'd6, 8'h41);
    wait_idle();
    op_valid = 1'b1;
    op       = 3'd6;
    @(posedge clk); #1;
    op_valid = 1'b0;
    hi  = 0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (in_ready) hi++;
      if (mem_load) bad++;
      @(posedge clk); #1;
    end
    if (in_ready) hi++;
    in_valid = 1'b1;
    in_data  = 8'h41;
    #1;
    check("in-cycle mem_load", {31'h0, mem_load}, 32'h1);
    check("in-cycle mem_wdata", {24'h0, mem_wdata}, 32'h41);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (in_ready) hi++;
    check("in_ready high cycles", hi, 32'd6);
    check("loads while stalled", bad, 32'd0);
    run_op(3'd5, 8'h00);

    // OUT stalled by console, reset lands mid-wait
    out_ready = 1'b0;
    op_valid  = 1'b1;
    op        = 3'd5;
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("out_valid while stalled", {31'h0, out_valid}, 32'h1);
    @(posedge clk); #1;
    check("out_data held", {24'h0, out_data}, {24'h0, tape_m[dp_m]});
    #2 rst_n = 1'b0;
    #1;
    check("out_valid in reset", {31'h0, out_valid}, 32'h0);
    check("mem_load in reset", {31'h0, mem_load}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dp_m  = 8'h00;
    @(posedge clk); #1;
    check("post-reset dp", {24'h0, dp}, 32'h0);
    check("post-reset op_ready", {31'h0, op_ready}, 32'h1);
    check("post-reset out_valid", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b1;

    // 256 back-to-back RIGHTs
    bad      = 0;
    op_valid = 1'b1;
    op       = 3'd3;
    for (int i = 0; i < 256; i++) begin
      if (!op_ready) bad++;
      @(posedge clk); #1;
      if (i == 99) check("dp after 100 RIGHT", {24'h0, dp}, 32'd100);
    end
    op_valid = 1'b0;
    op       = 3'd0;
    check("op_ready drops during RIGHT burst", bad, 32'd0);
    check("dp after 256 RIGHT", {24'h0, dp}, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    check("pending writes left", exp_wr.size(), 32'd0);
    check("pending outputs left", exp_out.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
